// File: rtl/order_decision_engine_if.sv
// Tick and order channel bundle between feed, strategy core and order entry.
// Latency: none, this is wiring only.
// Backpressure: md_ready and ord_ready are plain valid/ready acceptance flags.
interface order_decision_engine_if #(
    parameter int PRICE_W = 32
);
    logic               md_valid;
    logic [PRICE_W-1:0] md_bid_price;
    logic [PRICE_W-1:0] md_ask_price;
    logic               md_ready;
    logic               ord_valid;
    logic               ord_side;
    logic [PRICE_W-1:0] ord_price;
    logic [PRICE_W-1:0] ord_qty;
    logic               ord_ready;

    // Feed / order-entry side: sources ticks, sinks orders.
    modport master (
        output md_valid, md_bid_price, md_ask_price, ord_ready,
        input  md_ready, ord_valid, ord_side, ord_price, ord_qty
    );

    // Engine side: sinks ticks, sources orders.
    modport slave (
        input  md_valid, md_bid_price, md_ask_price, ord_ready,
        output md_ready, ord_valid, ord_side, ord_price, ord_qty
    );
endinterface

// File: rtl/order_decision_engine.sv
// Compares market ticks with configured limits and issues at most one order per tick.
// Latency: tick accept at E, decision in E+1, ord_valid after E+2; optional cooldown after each order.
// Backpressure: md_ready only in IDLE; order fields held until ord_ready, one order outstanding.
module order_decision_engine #(
    parameter int PRICE_W      = 32,   // must be <= 32 so the 34-bit position maths cannot wrap
    parameter int MAX_POSITION = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    order_decision_engine_if.slave bus,
    input  logic [PRICE_W-1:0]  buy_price_limit,
    input  logic [PRICE_W-1:0]  sell_price_limit,
    input  logic [PRICE_W-1:0]  buy_quantity,
    input  logic [PRICE_W-1:0]  sell_quantity,
    input  logic [7:0]          strategy_mode,
    input  logic [15:0]         strategy_params,
    input  logic                config_updated,
    output logic signed [31:0]  position,
    output logic [15:0]         order_count
);
    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_ISSUE, S_COOLDOWN} state_t;

    localparam logic signed [33:0] MAX_POS = 34'(MAX_POSITION);

    state_t             state, state_nxt;
    logic [PRICE_W-1:0] snap_bid, snap_ask;
    logic [PRICE_W-1:0] snap_buy_lim, snap_sell_lim;
    logic [PRICE_W-1:0] snap_buy_qty, snap_sell_qty;
    logic [7:0]         snap_mode;
    logic [15:0]        snap_params;
    logic [15:0]        cd_cnt;

    logic signed [33:0] pos_ext, buy_pos, sell_pos;
    logic               buy_ok, sell_ok, dec_vld, dec_sell;
    logic               md_hs, ord_hs;

    assign md_hs  = bus.md_valid && (state == S_IDLE);
    assign ord_hs = (state == S_ISSUE) && bus.ord_ready;

    // Position checks run 34 bits wide so a large lot size cannot wrap past the limit.
    assign pos_ext  = {{2{position[31]}}, position};
    assign buy_pos  = pos_ext + $signed({{(34-PRICE_W){1'b0}}, snap_buy_qty});
    assign sell_pos = pos_ext - $signed({{(34-PRICE_W){1'b0}}, snap_sell_qty});
    assign buy_ok   = (snap_ask <= snap_buy_lim)  && (buy_pos  <= MAX_POS);
    assign sell_ok  = (snap_bid >= snap_sell_lim) && (sell_pos >= -MAX_POS);

    // Strategy decision from snapshot values; buy has priority in two-sided mode.
    always_comb begin
        dec_vld  = 1'b0;
        dec_sell = 1'b0;
        case (snap_mode)
            8'h01: begin
                if (buy_ok) begin
                    dec_vld = 1'b1;
                end else if (sell_ok) begin
                    dec_vld  = 1'b1;
                    dec_sell = 1'b1;
                end
            end
            8'h02: dec_vld = buy_ok;
            8'h03: begin
                dec_vld  = sell_ok;
                dec_sell = 1'b1;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a config write aborts everything except an order in flight.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (!config_updated && bus.md_valid) state_nxt = S_EVAL;
            S_EVAL:     state_nxt = (!config_updated && dec_vld) ? S_ISSUE : S_IDLE;
            S_ISSUE:    if (bus.ord_ready) state_nxt = (snap_params == 16'd0) ? S_IDLE : S_COOLDOWN;
            S_COOLDOWN: if (config_updated || cd_cnt <= 16'd1) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded straight from state.
    always_comb begin
        bus.md_ready  = (state == S_IDLE);
        bus.ord_valid = (state == S_ISSUE);
    end

    // Tick and configuration snapshot, taken only on an accepted tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_bid      <= '0;
            snap_ask      <= '0;
            snap_buy_lim  <= '0;
            snap_sell_lim <= '0;
            snap_buy_qty  <= '0;
            snap_sell_qty <= '0;
            snap_mode     <= '0;
            snap_params   <= '0;
        end else if (md_hs && !config_updated) begin
            snap_bid      <= bus.md_bid_price;
            snap_ask      <= bus.md_ask_price;
            snap_buy_lim  <= buy_price_limit;
            snap_sell_lim <= sell_price_limit;
            snap_buy_qty  <= buy_quantity;
            snap_sell_qty <= sell_quantity;
            snap_mode     <= strategy_mode;
            snap_params   <= strategy_params;
        end
    end

    // Order fields registered at the end of EVAL and held through ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ord_side  <= 1'b0;
            bus.ord_price <= '0;
            bus.ord_qty   <= '0;
        end else if (state == S_EVAL && dec_vld && !config_updated) begin
            bus.ord_side  <= dec_sell;
            bus.ord_price <= dec_sell ? snap_bid : snap_ask;
            bus.ord_qty   <= dec_sell ? snap_sell_qty : snap_buy_qty;
        end
    end

    // Position and order count move only when the order is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position    <= '0;
            order_count <= '0;
        end else if (ord_hs) begin
            position    <= bus.ord_side ? position - 32'(bus.ord_qty) : position + 32'(bus.ord_qty);
            order_count <= order_count + 16'd1;
        end
    end

    // Cooldown counter: loaded on the order handshake, cleared by a config write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd_cnt <= '0;
        end else if (config_updated && state != S_ISSUE) begin
            cd_cnt <= '0;
        end else if (ord_hs) begin
            cd_cnt <= snap_params;
        end else if (state == S_COOLDOWN && cd_cnt != 16'd0) begin
            cd_cnt <= cd_cnt - 16'd1;
        end
    end
endmodule

// File: tb/tb_order_decision_engine.sv
// Scoreboard bench for order_decision_engine with a reduced position limit.
// Latency: checks tick-to-order, cooldown length and handshake timing.
// Backpressure: holds ord_ready low to check order stability.
module tb_order_decision_engine;
    localparam longint TB_MAX = 2;

    typedef struct {
        logic        side;
        logic [31:0] price;
        logic [31:0] qty;
    } ord_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] buy_lim, sell_lim, buy_qty, sell_qty;
    logic [7:0]  mode;
    logic [15:0] params;
    logic        cfg_upd;
    logic signed [31:0] position;
    logic [15:0] order_count;

    ord_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   mdl_pos = 0;
    logic [15:0] mdl_cnt = '0;

    always #5 clk = ~clk;

    order_decision_engine_if #(.PRICE_W(32)) bus();

    order_decision_engine #(.PRICE_W(32), .MAX_POSITION(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .buy_price_limit  (buy_lim),
        .sell_price_limit (sell_lim),
        .buy_quantity     (buy_qty),
        .sell_quantity    (sell_qty),
        .strategy_mode    (mode),
        .strategy_params  (params),
        .config_updated   (cfg_upd),
        .position         (position),
        .order_count      (order_count)
    );

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        mdl_pos = 0;
        mdl_cnt = '0;
        @(negedge clk);
    endtask

    // Drives one tick; pushes the expected order (if any) onto the scoreboard.
    // Returns at the negedge inside the EVAL cycle.
    task automatic send_tick(input logic [31:0] bid, input logic [31:0] ask, output bit has_ord);
        ord_t o;
        bit   b_ok, s_ok;
        longint p;
        @(negedge clk);
        checks++;
        if (bus.md_ready !== 1'b1) begin
            failures++;
            $display("FAIL tick_md_ready got=%b want=1", bus.md_ready);
        end
        p    = mdl_pos;
        b_ok = (ask <= buy_lim) && (p + longint'(buy_qty) <= TB_MAX);
        s_ok = (bid >= sell_lim) && (p - longint'(sell_qty) >= -TB_MAX);
        has_ord = 1'b0;
        case (mode)
            8'h01: begin
                if (b_ok) begin has_ord = 1'b1; o.side = 1'b0; end
                else if (s_ok) begin has_ord = 1'b1; o.side = 1'b1; end
            end
            8'h02: if (b_ok) begin has_ord = 1'b1; o.side = 1'b0; end
            8'h03: if (s_ok) begin has_ord = 1'b1; o.side = 1'b1; end
            default: ;
        endcase
        if (has_ord) begin
            o.price = o.side ? bid : ask;
            o.qty   = o.side ? sell_qty : buy_qty;
            exp_q.push_back(o);
        end
        bus.md_valid     = 1'b1;
        bus.md_bid_price = bid;
        bus.md_ask_price = ask;
        @(negedge clk);
        bus.md_valid = 1'b0;
        checks++;
        if (bus.md_ready !== 1'b0) begin
            failures++;
            $display("FAIL eval_md_ready got=%b want=0", bus.md_ready);
        end
    endtask

    // Waits for the pending order, holds it for 'hold' cycles, then takes it.
    task automatic collect_order(input int hold);
        ord_t e;
        int   n;
        n = 0;
        while (bus.ord_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.ord_valid !== 1'b1) begin
            failures++;
            $display("FAIL order_timeout ord_valid=%b want=1", bus.ord_valid);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_order side=%b price=%0d qty=%0d", bus.ord_side, bus.ord_price, bus.ord_qty);
            return;
        end
        e = exp_q[0];
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (bus.ord_valid !== 1'b1 || bus.ord_side !== e.side || bus.ord_price !== e.price ||
                bus.ord_qty !== e.qty || position !== mdl_pos) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d got v=%b s=%b p=%0d q=%0d pos=%0d want v=1 s=%b p=%0d q=%0d pos=%0d",
                         i, bus.ord_valid, bus.ord_side, bus.ord_price, bus.ord_qty, position,
                         e.side, e.price, e.qty, mdl_pos);
            end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.ord_side !== e.side || bus.ord_price !== e.price || bus.ord_qty !== e.qty) begin
            failures++;
            $display("FAIL order_fields got s=%b p=%0d q=%0d want s=%b p=%0d q=%0d",
                     bus.ord_side, bus.ord_price, bus.ord_qty, e.side, e.price, e.qty);
        end
        bus.ord_ready = 1'b1;
        @(negedge clk);
        bus.ord_ready = 1'b0;
        mdl_pos = e.side ? mdl_pos - int'(e.qty) : mdl_pos + int'(e.qty);
        mdl_cnt = mdl_cnt + 16'd1;
        checks++;
        if (position !== mdl_pos || order_count !== mdl_cnt || bus.ord_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_handshake got pos=%0d cnt=%0d v=%b want pos=%0d cnt=%0d v=0",
                     position, order_count, bus.ord_valid, mdl_pos, mdl_cnt);
        end
    endtask

    task automatic expect_order_at_e2();
        @(negedge clk);
        checks++;
        if (bus.ord_valid !== 1'b1) begin
            failures++;
            $display("FAIL order_latency ord_valid=%b want=1", bus.ord_valid);
        end
    endtask

    task automatic expect_idle_at_e2(input string tag);
        @(negedge clk);
        checks++;
        if (bus.md_ready !== 1'b1 || bus.ord_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s md_ready=%b ord_valid=%b want 1/0", tag, bus.md_ready, bus.ord_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.md_ready !== 1'b1 || bus.ord_valid !== 1'b0 || bus.ord_side !== 1'b0 ||
            bus.ord_price !== 32'd0 || bus.ord_qty !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs rdy=%b v=%b s=%b p=%0d q=%0d want 1 0 0 0 0",
                     bus.md_ready, bus.ord_valid, bus.ord_side, bus.ord_price, bus.ord_qty);
        end
        checks++;
        if (position !== 32'sd0 || order_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters pos=%0d cnt=%0d want 0 0", position, order_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.md_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release md_ready=%b want=1", bus.md_ready);
        end
    endtask

    task automatic test_mode_off();
        bit h;
        mode = 8'h00; buy_lim = 32'd43200; sell_lim = 32'd44800;
        buy_qty = 32'd1; sell_qty = 32'd1; params = 16'd0;
        send_tick(32'd44900, 32'd43000, h);
        expect_idle_at_e2("mode_off_idle");
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL mode_off_model queued=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_buy_basic();
        bit h;
        mode = 8'h01;
        send_tick(32'd43000, 32'd43100, h);
        expect_order_at_e2();
        collect_order(0);
    endtask

    task automatic test_backpressure();
        bit h;
        send_tick(32'd43000, 32'd43100, h);
        expect_order_at_e2();
        collect_order(5);
    endtask

    task automatic test_position_limit();
        bit h;
        apply_reset();
        mode = 8'h01; params = 16'd0;
        for (int i = 0; i < 2; i++) begin
            send_tick(32'd43000, 32'd43100, h);
            expect_order_at_e2();
            collect_order(0);
        end
        send_tick(32'd43000, 32'd43100, h);
        expect_idle_at_e2("limit_blocks_buy");
        send_tick(32'd44900, 32'd45000, h);
        expect_order_at_e2();
        collect_order(1);
    endtask

    task automatic test_modes();
        bit h;
        mode = 8'h03;
        send_tick(32'd44900, 32'd43000, h);
        expect_order_at_e2();
        collect_order(0);
        mode = 8'h02;
        send_tick(32'd44900, 32'd45000, h);
        expect_idle_at_e2("buy_only_no_sell");
        mode = 8'h07;
        send_tick(32'd44900, 32'd43000, h);
        expect_idle_at_e2("unknown_mode");
    endtask

    task automatic test_cooldown();
        bit h;
        int lows;
        mode = 8'h01; params = 16'h0010;
        send_tick(32'd43000, 32'd43100, h);
        expect_order_at_e2();
        collect_order(0);
        lows = 0;
        while (bus.md_ready !== 1'b1 && lows < 100) begin
            lows++;
            @(negedge clk);
        end
        checks++;
        if (lows != 16) begin
            failures++;
            $display("FAIL cooldown_len low_cycles=%0d want=16", lows);
        end
        send_tick(32'd43000, 32'd43100, h);
        expect_order_at_e2();
        collect_order(0);
        repeat (4) @(negedge clk);
        checks++;
        if (bus.md_ready !== 1'b0) begin
            failures++;
            $display("FAIL cooldown_mid md_ready=%b want=0", bus.md_ready);
        end
        cfg_upd = 1'b1;
        @(negedge clk);
        cfg_upd = 1'b0;
        checks++;
        if (bus.md_ready !== 1'b1) begin
            failures++;
            $display("FAIL cooldown_abort md_ready=%b want=1", bus.md_ready);
        end
        params = 16'd0;
    endtask

    task automatic test_config_collision();
        bit h;
        @(negedge clk);
        bus.md_valid = 1'b1; bus.md_bid_price = 32'd44900; bus.md_ask_price = 32'd45000;
        cfg_upd = 1'b1;
        @(negedge clk);
        bus.md_valid = 1'b0; cfg_upd = 1'b0;
        checks++;
        if (bus.md_ready !== 1'b1) begin
            failures++;
            $display("FAIL tick_dropped md_ready=%b want=1", bus.md_ready);
        end
        expect_idle_at_e2("tick_dropped_no_order");
        send_tick(32'd44900, 32'd45000, h);
        if (h) void'(exp_q.pop_back());
        cfg_upd = 1'b1;
        @(negedge clk);
        cfg_upd = 1'b0;
        checks++;
        if (bus.md_ready !== 1'b1 || bus.ord_valid !== 1'b0) begin
            failures++;
            $display("FAIL eval_discard md_ready=%b ord_valid=%b want 1/0", bus.md_ready, bus.ord_valid);
        end
        expect_idle_at_e2("eval_discard_no_order");
        checks++;
        if (position !== mdl_pos || order_count !== mdl_cnt) begin
            failures++;
            $display("FAIL cfg_no_effect pos=%0d cnt=%0d want pos=%0d cnt=%0d", position, order_count, mdl_pos, mdl_cnt);
        end
    endtask

    task automatic test_reset_mid_issue();
        bit h;
        send_tick(32'd44900, 32'd45000, h);
        expect_order_at_e2();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ord_valid !== 1'b0 || position !== 32'sd0 || order_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid_issue v=%b pos=%0d cnt=%0d want 0 0 0", bus.ord_valid, position, order_count);
        end
        exp_q.delete();
        mdl_pos = 0;
        mdl_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.md_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_release md_ready=%b want=1", bus.md_ready);
        end
        send_tick(32'd43000, 32'd43100, h);
        expect_order_at_e2();
        collect_order(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.md_valid = 1'b0; bus.md_bid_price = '0; bus.md_ask_price = '0; bus.ord_ready = 1'b0;
        buy_lim = '0; sell_lim = '0; buy_qty = '0; sell_qty = '0;
        mode = '0; params = '0; cfg_upd = 1'b0;
        test_reset();
        test_mode_off();
        test_buy_basic();
        test_backpressure();
        test_position_limit();
        test_modes();
        test_cooldown();
        test_config_collision();
        test_reset_mid_issue();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover queued=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
